// File: rtl/sram_stream_fifo_ctrl.sv
// sram_stream_fifo_ctrl: valid/ready stream FIFO controller in front of a 1-cycle-latency dual-port SRAM
//
// Port A of the SRAM is the write port, port B the read port. Input words are written straight
// into the SRAM. A small read FSM fetches them back into a registered output stage.
//
// Ports:
//   Clk_In, Reset_In       clock, synchronous active-low reset
//   Flush_In               synchronous flush; like reset but Out_Data is kept
//   In_Data/Valid/Ready    write stream (In_Ready = !Full)
//   Out_Data/Valid/Ready   registered read stream
//   Full, Empty, Level     status; Level counts SRAM + in-flight read + output register
//   Sram_A_*               write port drive (read enable tied low)
//   Sram_B_*               read port drive (write enable tied low), Sram_B_Data returns read data
module sram_stream_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Flush_In,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Level,
    output logic [DATA_WIDTH-1:0] Sram_A_Data,
    output logic [ADDR_WIDTH-1:0] Sram_A_Address,
    output logic                  Sram_A_Write_Enable,
    output logic                  Sram_A_Read_Enable,
    output logic [ADDR_WIDTH-1:0] Sram_B_Address,
    output logic                  Sram_B_Read_Enable,
    output logic                  Sram_B_Write_Enable,
    input  logic [DATA_WIDTH-1:0] Sram_B_Data
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_stored;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_clear;
    logic                  w_wr_fire;
    logic                  w_has;
    logic                  w_rd_issue;
    logic                  w_load;
    assign w_clear   = !Reset_In || Flush_In;
    assign Full      = r_stored == DEPTH;
    assign In_Ready  = !Full;
    // Writes during a reset/flush cycle would land behind a pointer that is being cleared.
    assign w_wr_fire = In_Valid && In_Ready && !w_clear;
    assign w_has     = r_stored != '0;
    always_comb begin
        w_next     = r_state;
        w_rd_issue = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            IDLE: begin
                w_rd_issue = w_has;
                w_next     = w_has ? FETCH : IDLE;
            end
            FETCH: begin
                w_load = 1'b1;
                w_next = VALID;
            end
            VALID: begin
                w_rd_issue = Out_Ready && w_has;
                w_next     = !Out_Ready ? VALID : w_has ? FETCH : IDLE;
            end
            default: w_next = IDLE;
        endcase
        w_rd_issue = w_rd_issue && !w_clear;
    end
    always_ff @(posedge Clk_In) begin
        if (w_clear) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_stored    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(w_wr_fire);
            r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(w_rd_issue);
            r_stored    <= r_stored + (ADDR_WIDTH+1)'(w_wr_fire) - (ADDR_WIDTH+1)'(w_rd_issue);
            r_out_valid <= w_next == VALID;
        end
    end
    // Output data survives a flush; only reset clears it.
    always_ff @(posedge Clk_In) begin
        if (!Reset_In) r_out_data <= '0;
        else if (!Flush_In && w_load) r_out_data <= Sram_B_Data;
    end
    assign Out_Data            = r_out_data;
    assign Out_Valid           = r_out_valid;
    assign Level               = r_stored + (ADDR_WIDTH+1)'(r_state == FETCH) + (ADDR_WIDTH+1)'(r_out_valid);
    assign Empty               = Level == '0;
    assign Sram_A_Data         = In_Data;
    assign Sram_A_Address      = r_wr_ptr;
    assign Sram_A_Write_Enable = w_wr_fire;
    assign Sram_A_Read_Enable  = 1'b0;
    assign Sram_B_Address      = r_rd_ptr;
    assign Sram_B_Read_Enable  = w_rd_issue;
    assign Sram_B_Write_Enable = 1'b0;
endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
// tb_sram_stream_fifo_ctrl: directed vector table plus scoreboarded sequences for the SRAM FIFO controller
module tb_sram_stream_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       full;
    logic       empty;
    logic [8:0] level;
    logic [7:0] a_data;
    logic [7:0] a_addr;
    logic       a_we;
    logic       a_re;
    logic [7:0] b_addr;
    logic       b_re;
    logic       b_we;
    logic [7:0] b_data = 8'h00;
    logic [7:0] mem [256];

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    sram_stream_fifo_ctrl dut (
        .Clk_In(clk), .Reset_In(rst_n), .Flush_In(flush),
        .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
        .Out_Data(out_data), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Full(full), .Empty(empty), .Level(level),
        .Sram_A_Data(a_data), .Sram_A_Address(a_addr), .Sram_A_Write_Enable(a_we),
        .Sram_A_Read_Enable(a_re), .Sram_B_Address(b_addr), .Sram_B_Read_Enable(b_re),
        .Sram_B_Write_Enable(b_we), .Sram_B_Data(b_data)
    );

    // 256x8 dual-port SRAM with registered port-B read
    always @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_data;
        if (b_re) b_data <= mem[b_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Output handshake log and stall-stability check
    logic       p_stall = 1'b0;
    logic [7:0] p_data = 8'h00;
    always @(posedge clk) begin
        if (p_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, p_data);
        end
        p_stall <= rst_n && !flush && out_valid && !out_ready;
        p_data  <= out_data;
        if (rst_n && !flush && out_valid && out_ready) got_q.push_back(out_data);
    end

    typedef struct {
        logic       rst_n, flush, iv;
        logic [7:0] id;
        logic       ordy, chk_pre, awe;
        logic [7:0] aaddr;
        logic       bre;
        logic [8:0] lvl;
        logic       ov;
        logic [7:0] od;
    } vec_t;
    vec_t tv[15];

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [7:0] d);
        int  t = 0;
        bit  acc = 0;
        in_valid = 1; in_data = d;
        while (!acc && t < 2000) begin
            #1 acc = in_ready;
            @(negedge clk);
            t++;
        end
        in_valid = 0;
        chk("push_accept", acc, 1);
        if (acc) exp_q.push_back(d);
    endtask

    task automatic drain(input int n);
        int t = 0;
        out_ready = 1;
        while (got_q.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        out_ready = 0;
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic flush_case(input bit use_rst);
        int t = 0;
        reset_dut();
        for (int i = 0; i < 11; i++) push(8'(8'h40 + i));
        repeat (4) @(negedge clk);
        chk("fl_level11", level, 11);
        chk("fl_valid", out_valid, 1);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("fl_fetch_level", level, 10);
        chk("fl_fetch_ov", out_valid, 0);
        if (use_rst) rst_n = 0; else flush = 1;
        @(negedge clk);
        rst_n = 1; flush = 0;
        chk("fl_level0", level, 0);
        chk("fl_ov0", out_valid, 0);
        chk("fl_empty", empty, 1);
        if (use_rst) chk("rst_od0", out_data, 0);
        got_q.delete();
        exp_q.delete();
        push(8'h3C);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("fl_first_valid", out_valid, 1);
        chk("fl_first_data", out_data, 8'h3C);
        drain(1);
        compare("fl_stream");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        //        rst flush iv id     ordy pre awe aaddr bre lvl ov od
        tv[0]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 9'd0, 0, 8'h00};
        tv[1]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd0, 0, 8'h00};
        tv[2]  = '{1, 0, 1, 8'hA5, 0, 1, 1, 8'h00, 0, 9'd1, 0, 8'h00};
        tv[3]  = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 9'd1, 0, 8'h00};
        tv[4]  = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd1, 1, 8'hA5};
        tv[5]  = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd1, 1, 8'hA5};
        tv[6]  = '{1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 9'd0, 0, 8'hA5};
        tv[7]  = '{1, 0, 1, 8'h11, 1, 1, 1, 8'h01, 0, 9'd1, 0, 8'hA5};
        tv[8]  = '{1, 0, 1, 8'h22, 1, 1, 1, 8'h02, 1, 9'd2, 0, 8'hA5};
        tv[9]  = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd2, 1, 8'h11};
        tv[10] = '{1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 9'd1, 0, 8'h11};
        tv[11] = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd1, 1, 8'h22};
        tv[12] = '{1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd0, 0, 8'h22};
        tv[13] = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd0, 0, 8'h00};
        tv[14] = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 9'd0, 0, 8'h00};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n; flush = tv[i].flush; in_valid = tv[i].iv;
            in_data = tv[i].id; out_ready = tv[i].ordy;
            #1;
            if (tv[i].chk_pre) begin
                chk($sformatf("v%0d_a_we", i), a_we, tv[i].awe);
                if (tv[i].awe) chk($sformatf("v%0d_a_addr", i), a_addr, tv[i].aaddr);
                chk($sformatf("v%0d_b_re", i), b_re, tv[i].bre);
            end
            chk($sformatf("v%0d_ties", i), {a_re, b_we}, 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), level, tv[i].lvl);
            chk($sformatf("v%0d_out_valid", i), out_valid, tv[i].ov);
            chk($sformatf("v%0d_out_data", i), out_data, tv[i].od);
            chk($sformatf("v%0d_empty", i), empty, tv[i].lvl == 0);
            chk($sformatf("v%0d_full", i), full, 0);
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
        end

        // Fill past wrap, check full, blocked write, drain order
        reset_dut();
        for (int i = 0; i < 257; i++) begin
            if (i == 256) begin
                chk("fill_level256", level, 256);
                chk("fill_not_full", full, 0);
                chk("fill_wrap_addr", a_addr, 0);
            end
            push(8'(i));
        end
        chk("fill_full", full, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_level257", level, 257);
        in_valid = 1; in_data = 8'hEE;
        #1 chk("full_no_write", a_we, 0);
        @(negedge clk);
        in_valid = 0;
        chk("full_level_hold", level, 257);
        drain(257);
        compare("fill_order");
        chk("drain_empty", empty, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("post_wrap_addr%0d", i), a_addr, i + 1);
            push(8'(8'hB0 + i));
        end
        drain(5);
        compare("post_wrap");

        // Continuous stream with a ready consumer
        begin
            bit nf = 1;
            int lmax = 0;
            reset_dut();
            out_ready = 1;
            for (int i = 0; i < 200; i++) begin
                if (full) nf = 0;
                if (int'(level) > lmax) lmax = int'(level);
                push(8'(i));
            end
            chk("stream_never_full", nf, 1);
            chk("stream_level_bound", lmax <= 128, 1);
            drain(200);
            compare("stream");
        end

        // Random backpressure over 500 words
        reset_dut();
        fork
            for (int i = 0; i < 500; i++) push(8'($urandom_range(0, 255)));
            begin
                int t = 0;
                while (got_q.size() < 500 && t < 20000) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    t++;
                end
                out_ready = 0;
            end
        join
        compare("backpressure");

        flush_case(0);
        flush_case(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
